// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC, synchronous ROM request and a small instruction FIFO with flush
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_code,
  output logic [31:0]                inst_pc,
  input  logic                       flush,
  input  logic [31:0]                flush_pc,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  logic [31:0] fpc;
  logic [31:0] infl_pc;
  logic infl;
  logic [31:0] code_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic push;
  logic pop;
  // Credit-based issue: buffered plus in-flight words never exceed the FIFO depth
  always_comb begin
    occ = {1'b0, count} + (CW+1)'(infl);
    rom_en = rst & ~flush & (occ < DEPTH_C);
    rom_addr = fpc[ADDR_W+1:2];
    inst_valid = rst & (count != '0);
    inst_code = inst_valid ? code_q[rd_ptr] : '0;
    inst_pc = inst_valid ? pc_q[rd_ptr] : '0;
    level = rst ? count : '0;
    push = infl & ~flush;
    pop = inst_valid & inst_ready;
  end
  // Reset beats flush, flush beats normal issue/push/pop
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc <= RESET_PC;
      infl <= 1'b0;
      infl_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        code_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (flush) begin
      fpc <= flush_pc & ~32'd3;
      infl <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      infl <= rom_en;
      if (rom_en) begin
        infl_pc <= fpc;
        fpc <= fpc + 32'd4;
      end
      if (push) begin
        code_q[wr_ptr] <= rom_data;
        pc_q[wr_ptr] <= infl_pc;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
